// File: rtl/mem_ctrl_if.sv
// Request/response port bundle between a command source and mem_ctrl.
// The source drives cmd_* and rsp_ready; the controller drives cmd_ready and rsp_*.
interface mem_ctrl_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [DATA_W-1:0] rsp_rdata;
    logic [ADDR_W-1:0] rsp_addr;

    modport master (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_addr
    );

    modport slave (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_addr
    );
endinterface

// File: rtl/mem_ctrl.sv
// Command front-end for a synchronous single-port memory: serialises read/write
// requests into one-cycle strobes and returns read data on a valid/ready port.
module mem_ctrl #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    mem_ctrl_if.slave         bus,
    output logic              mem_write,
    output logic              mem_read,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              busy
);
    typedef enum logic [2:0] {IDLE, WR, RD, RD_WAIT, RSP} state_t;

    state_t            state_reg,       state_next;
    logic              cmd_ready_reg,   cmd_ready_next;
    logic              rsp_valid_reg,   rsp_valid_next;
    logic [DATA_W-1:0] rsp_rdata_reg,   rsp_rdata_next;
    logic [ADDR_W-1:0] rsp_addr_reg,    rsp_addr_next;
    logic              mem_write_reg,   mem_write_next;
    logic              mem_read_reg,    mem_read_next;
    logic [ADDR_W-1:0] mem_addr_reg,    mem_addr_next;
    logic [DATA_W-1:0] mem_data_in_reg, mem_data_in_next;
    logic              busy_reg,        busy_next;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= IDLE;
            cmd_ready_reg   <= 1'b0;
            rsp_valid_reg   <= 1'b0;
            rsp_rdata_reg   <= '0;
            rsp_addr_reg    <= '0;
            mem_write_reg   <= 1'b0;
            mem_read_reg    <= 1'b0;
            mem_addr_reg    <= '0;
            mem_data_in_reg <= '0;
            busy_reg        <= 1'b0;
        end else begin
            state_reg       <= state_next;
            cmd_ready_reg   <= cmd_ready_next;
            rsp_valid_reg   <= rsp_valid_next;
            rsp_rdata_reg   <= rsp_rdata_next;
            rsp_addr_reg    <= rsp_addr_next;
            mem_write_reg   <= mem_write_next;
            mem_read_reg    <= mem_read_next;
            mem_addr_reg    <= mem_addr_next;
            mem_data_in_reg <= mem_data_in_next;
            busy_reg        <= busy_next;
        end
    end

    // Strobes default low so each can only be high for the single cycle after acceptance;
    // only one of them is ever raised per accepted command, so they can never overlap.
    always_comb begin
        state_next       = state_reg;
        rsp_valid_next   = rsp_valid_reg;
        rsp_rdata_next   = rsp_rdata_reg;
        rsp_addr_next    = rsp_addr_reg;
        mem_write_next   = 1'b0;
        mem_read_next    = 1'b0;
        mem_addr_next    = mem_addr_reg;
        mem_data_in_next = mem_data_in_reg;

        case (state_reg)
            IDLE: begin
                if (bus.cmd_valid && cmd_ready_reg) begin
                    mem_addr_next = bus.cmd_addr;
                    if (bus.cmd_write) begin
                        state_next       = WR;
                        mem_data_in_next = bus.cmd_wdata;
                        mem_write_next   = 1'b1;
                    end else begin
                        state_next    = RD;
                        rsp_addr_next = bus.cmd_addr;
                        mem_read_next = 1'b1;
                    end
                end
            end
            WR:      state_next = IDLE;
            RD:      state_next = RD_WAIT;
            RD_WAIT: begin
                // Memory output became valid on the edge that ended RD.
                state_next     = RSP;
                rsp_rdata_next = mem_data_out;
                rsp_valid_next = 1'b1;
            end
            RSP: begin
                if (bus.rsp_ready) begin
                    state_next     = IDLE;
                    rsp_valid_next = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase

        cmd_ready_next = (state_next == IDLE);
        busy_next      = (state_next != IDLE);
    end

    assign bus.cmd_ready = cmd_ready_reg;
    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_rdata = rsp_rdata_reg;
    assign bus.rsp_addr  = rsp_addr_reg;
    assign mem_write     = mem_write_reg;
    assign mem_read      = mem_read_reg;
    assign mem_addr      = mem_addr_reg;
    assign mem_data_in   = mem_data_in_reg;
    assign busy          = busy_reg;
endmodule

// File: tb/tb_mem_ctrl.sv
// Directed and random checks of mem_ctrl against a behavioural 32x8 synchronous memory
// and a reference array of expected contents.
module tb_mem_ctrl;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_ctrl_if #(.ADDR_W(5), .DATA_W(8)) bus ();

    logic       mem_write;
    logic       mem_read;
    logic [4:0] mem_addr;
    logic [7:0] mem_data_in;
    logic [7:0] mem_data_out;
    logic       busy;

    mem_ctrl #(.ADDR_W(5), .DATA_W(8)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .bus          (bus.slave),
        .mem_write    (mem_write),
        .mem_read     (mem_read),
        .mem_addr     (mem_addr),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .busy         (busy)
    );

    // Memory itself is never reset, so its contents survive a controller reset.
    logic [7:0] mem [32];
    logic       mem_init_done = 1'b0;
    always @(posedge clk) begin
        if (!mem_init_done) begin
            for (int i = 0; i < 32; i++) mem[i] <= 8'(i * 3 + 1);
            mem_data_out  <= 8'h00;
            mem_init_done <= 1'b1;
        end else begin
            if (mem_write) mem[mem_addr] <= mem_data_in;
            if (mem_read)  mem_data_out  <= mem[mem_addr];
        end
    end

    int   n_overlap = 0;
    int   n_wide    = 0;
    logic prev_w    = 1'b0;
    logic prev_r    = 1'b0;
    always @(negedge clk) begin
        if (mem_read && mem_write) n_overlap++;
        if ((mem_write && prev_w) || (mem_read && prev_r)) n_wide++;
        prev_w = mem_write;
        prev_r = mem_read;
    end

    logic [7:0] ref_mem [32];
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    endtask

    function automatic logic [31:0] outs();
        return {1'b0, bus.cmd_ready, bus.rsp_valid, bus.rsp_rdata, bus.rsp_addr,
                mem_write, mem_read, mem_addr, mem_data_in, busy};
    endfunction

    // Presents a command and returns #1 after the accepting edge; cmd_valid is left high.
    task automatic send(input logic w, input logic [4:0] a, input logic [7:0] d, output int waited);
        bus.cmd_valid = 1'b1;
        bus.cmd_write = w;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        waited = 0;
        @(negedge clk);
        while (!bus.cmd_ready && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 40) check("cmd_accept", 32'(bus.cmd_ready), 32'd1);
        @(posedge clk);
        #1;
        if (w) ref_mem[a] = d;
        $display("cmd %s addr=%0d data=0x%02h waited=%0d", w ? "WR" : "RD", a, d, waited);
    endtask

    task automatic wait_rsp(output int waited);
        waited = 0;
        @(negedge clk);
        while (!bus.rsp_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (waited >= 20) check("rsp_timeout", 32'(bus.rsp_valid), 32'd1);
    endtask

    task automatic do_read(input string tag, input logic [4:0] a, input int stall);
        int n;
        send(1'b0, a, 8'h00, n);
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = (stall == 0);
        wait_rsp(n);
        check({tag, "_data"}, 32'(bus.rsp_rdata), 32'(ref_mem[a]));
        check({tag, "_addr"}, 32'(bus.rsp_addr), 32'(a));
        $display("rsp addr=%0d data=0x%02h", bus.rsp_addr, bus.rsp_rdata);
        if (stall > 0) begin
            repeat (stall) @(negedge clk);
            bus.rsp_ready = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        int n;
        int cnt;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = '0;
        bus.cmd_wdata = '0;
        bus.rsp_ready = 1'b1;
        for (int i = 0; i < 32; i++) ref_mem[i] = 8'(i * 3 + 1);

        // Reset values
        repeat (3) @(negedge clk);
        check("rst_outputs", outs(), 32'h0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_cmd_ready", 32'(bus.cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);

        // 1: write A5 @5, read back with exact latency
        send(1'b1, 5'd5, 8'hA5, n);
        bus.cmd_valid = 1'b0;
        check("t1_wr_strobe", 32'({mem_write, mem_read}), 32'b10);
        check("t1_wr_addr", 32'(mem_addr), 32'd5);
        check("t1_wr_data", 32'(mem_data_in), 32'hA5);
        check("t1_wr_cmd_ready", 32'(bus.cmd_ready), 32'd0);
        @(posedge clk); #1;
        check("t1_wr_done", 32'({mem_write, mem_read, bus.cmd_ready}), 32'b001);
        send(1'b0, 5'd5, 8'h00, n);
        bus.cmd_valid = 1'b0;
        check("t1_rd_strobe", 32'({mem_write, mem_read}), 32'b01);
        check("t1_rsp_c1", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk); #1;
        check("t1_rsp_c2", 32'({bus.rsp_valid, mem_read}), 32'b00);
        @(posedge clk); #1;
        check("t1_rsp_c3", 32'(bus.rsp_valid), 32'd1);
        check("t1_rdata", 32'(bus.rsp_rdata), 32'hA5);
        check("t1_raddr", 32'(bus.rsp_addr), 32'd5);
        @(posedge clk); #1;
        check("t1_rsp_taken", 32'({bus.rsp_valid, bus.cmd_ready}), 32'b01);

        // 2: back-to-back writes at the address extremes
        send(1'b1, 5'd0, 8'h11, n);
        check("t2_wr0_ready", 32'(bus.cmd_ready), 32'd0);
        send(1'b1, 5'd31, 8'hFF, n);
        bus.cmd_valid = 1'b0;
        check("t2_wr_gap", 32'(n), 32'd1);
        check("t2_wr31_ready", 32'(bus.cmd_ready), 32'd0);
        check("t2_wr31_addr", 32'(mem_addr), 32'd31);
        do_read("t2_rd31", 5'd31, 0);
        check("t2_rd31_hand", 32'(bus.rsp_rdata), 32'hFF);
        do_read("t2_rd0", 5'd0, 0);
        check("t2_rd0_hand", 32'(bus.rsp_rdata), 32'h11);

        // 3: response backpressure for 5 clk
        bus.rsp_ready = 1'b0;
        send(1'b0, 5'd7, 8'h00, n);
        bus.cmd_valid = 1'b0;
        wait_rsp(n);
        repeat (5) begin
            check("t3_valid", 32'(bus.rsp_valid), 32'd1);
            check("t3_rdata", 32'(bus.rsp_rdata), 32'h16);
            check("t3_cmd_ready", 32'(bus.cmd_ready), 32'd0);
            check("t3_strobes", 32'({mem_write, mem_read}), 32'b00);
            @(negedge clk);
        end
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("t3_release", 32'({bus.rsp_valid, bus.cmd_ready, busy}), 32'b010);
        send(1'b1, 5'd7, 8'h77, n);
        bus.cmd_valid = 1'b0;
        check("t3_next_accept", 32'(n), 32'd0);
        check("t3_next_strobe", 32'(mem_write), 32'd1);

        // 4: read-after-write with cmd_valid held across both commands
        send(1'b1, 5'd9, 8'h3C, n);
        send(1'b0, 5'd9, 8'h00, n);
        bus.cmd_valid = 1'b0;
        wait_rsp(n);
        check("t4_raw_data", 32'(bus.rsp_rdata), 32'h3C);
        @(posedge clk); #1;

        // 5: reset during RD_WAIT drops the read
        send(1'b0, 5'd9, 8'h00, n);
        bus.cmd_valid = 1'b0;
        @(posedge clk); #2;
        check("t5_in_rd_wait", 32'({busy, mem_read, bus.rsp_valid}), 32'b100);
        rst_n = 1'b0;
        #1;
        check("t5_async_rst", outs(), 32'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (bus.rsp_valid) cnt++;
        end
        check("t5_no_rsp", 32'(cnt), 32'd0);
        do_read("t5_rd9", 5'd9, 0);
        check("t5_rd9_hand", 32'(bus.rsp_rdata), 32'h3C);

        // 6: random traffic against the reference array
        for (int k = 0; k < 1000; k++) begin
            logic       w;
            logic [4:0] a;
            logic [7:0] d;
            w = 1'($urandom_range(0, 1));
            a = 5'($urandom);
            d = 8'($urandom);
            if (w) begin
                send(1'b1, a, d, n);
                bus.cmd_valid = 1'b0;
            end else begin
                do_read("rnd", a, int'($urandom_range(0, 2)));
            end
        end
        check("strobe_overlap", 32'(n_overlap), 32'd0);
        check("strobe_width", 32'(n_wide), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
